decode_queue: RTL and testbench

DECODE_QUEUE -- requirements
Module: decode_queue

---
 rtl/decode_queue.sv | 208 ++++++++++++++++++++
 tb/tb_decode_queue.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/decode_queue.sv
// RV32I front-end decode stage: decodes the fetched instruction combinationally
// and buffers the decoded fields in a small in-order queue ahead of execute.
module decode_queue #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic            flush_i,
  output logic [4:0]      rs1_addr_o,
  output logic [4:0]      rs2_addr_o,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_instr,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_imm,
  output logic [4:0]      out_rd,
  output logic            out_rd_we,
  output logic            out_rs1_en,
  output logic            out_rs2_en,
  output logic            out_illegal
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef struct packed {
    logic [31:0]     instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    logic [4:0]      rd;
    logic            rd_we;
    logic            rs1_en;
    logic            rs2_en;
    logic            illegal;
  } entry_t;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) begin
      return {PTR_W{1'b0}};
    end else begin
      return p + PTR_W'(1);
    end
  endfunction

  logic [6:0]       w_opcode;
  logic             w_rs1_en;
  logic             w_rs2_en;
  logic             w_wb;
  logic             w_illegal;
  logic             w_rd_we;
  logic [4:0]       w_rd;
  logic [31:0]      w_imm32;
  logic [XLEN-1:0]  w_imm;
  entry_t           w_entry;
  entry_t           w_head;
  logic             w_push;
  logic             w_pop;

  entry_t           r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [CNT_W-1:0] r_count;

  assign w_opcode = in_instr[6:0];

  // Opcode classification and immediate selection for the incoming instruction.
  always_comb begin
    w_rs1_en  = 1'b0;
    w_rs2_en  = 1'b0;
    w_wb      = 1'b0;
    w_illegal = 1'b0;
    w_imm32   = 32'd0;
    case (w_opcode)
      OPC_LOAD: begin
        w_rs1_en = 1'b1;
        w_wb     = 1'b1;
        w_imm32  = {{20{in_instr[31]}}, in_instr[31:20]};
      end
      OPC_STORE: begin
        w_rs1_en = 1'b1;
        w_rs2_en = 1'b1;
        w_imm32  = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      end
      OPC_OP: begin
        w_rs1_en = 1'b1;
        w_rs2_en = 1'b1;
        w_wb     = 1'b1;
      end
      OPC_OP_IMM: begin
        w_rs1_en = 1'b1;
        w_wb     = 1'b1;
        w_imm32  = {{20{in_instr[31]}}, in_instr[31:20]};
      end
      OPC_BRANCH: begin
        w_rs1_en = 1'b1;
        w_rs2_en = 1'b1;
        w_imm32  = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                    in_instr[30:25], in_instr[11:8], 1'b0};
      end
      OPC_LUI, OPC_AUIPC: begin
        w_wb    = 1'b1;
        w_imm32 = {in_instr[31:12], 12'd0};
      end
      OPC_JAL: begin
        w_wb    = 1'b1;
        w_imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                   in_instr[20], in_instr[30:21], 1'b0};
      end
      OPC_JALR: begin
        w_rs1_en = 1'b1;
        w_wb     = 1'b1;
        w_imm32  = {{20{in_instr[31]}}, in_instr[31:20]};
      end
      OPC_SYSTEM: begin
        w_imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
      end
      default: begin
        w_illegal = 1'b1;
      end
    endcase
  end

  generate
    if (XLEN > 32) begin : g_imm_ext
      assign w_imm = {{(XLEN-32){w_imm32[31]}}, w_imm32};
    end else begin : g_imm_direct
      assign w_imm = w_imm32;
    end
  endgenerate

  // x0 is never a real destination, so writes to it are suppressed at decode.
  assign w_rd_we    = w_wb & (in_instr[11:7] != 5'd0);
  assign w_rd       = w_rd_we ? in_instr[11:7] : 5'd0;
  assign rs1_addr_o = w_rs1_en ? in_instr[19:15] : 5'd0;
  assign rs2_addr_o = w_rs2_en ? in_instr[24:20] : 5'd0;

  assign w_entry.instr   = in_instr;
  assign w_entry.pc      = in_pc;
  assign w_entry.imm     = w_imm;
  assign w_entry.rd      = w_rd;
  assign w_entry.rd_we   = w_rd_we;
  assign w_entry.rs1_en  = w_rs1_en;
  assign w_entry.rs2_en  = w_rs2_en;
  assign w_entry.illegal = w_illegal;

  // Readiness depends only on stored occupancy: a full queue never accepts even on a pop.
  assign in_ready  = (r_count < CNT_W'(DEPTH)) & ~flush_i;
  assign out_valid = (r_count != {CNT_W{1'b0}});
  assign w_push    = in_valid & in_ready;
  assign w_pop     = out_valid & out_ready;

  // Queue storage, pointers and occupancy; flush overrides push and pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= {PTR_W{1'b0}};
      r_rptr  <= {PTR_W{1'b0}};
      r_count <= {CNT_W{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (flush_i) begin
      r_wptr  <= {PTR_W{1'b0}};
      r_rptr  <= {PTR_W{1'b0}};
      r_count <= {CNT_W{1'b0}};
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= w_entry;
        r_wptr        <= ptr_inc(r_wptr);
      end
      if (w_pop) begin
        r_rptr <= ptr_inc(r_rptr);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Head fields are forced to zero whenever the queue is empty.
  assign w_head      = out_valid ? r_mem[r_rptr] : '0;
  assign out_instr   = w_head.instr;
  assign out_pc      = w_head.pc;
  assign out_imm     = w_head.imm;
  assign out_rd      = w_head.rd;
  assign out_rd_we   = w_head.rd_we;
  assign out_rs1_en  = w_head.rs1_en;
  assign out_rs2_en  = w_head.rs2_en;
  assign out_illegal = w_head.illegal;

endmodule

// File: tb/tb_decode_queue.sv
// Directed self-checking bench for decode_queue (XLEN=32, DEPTH=2).
module tb_decode_queue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        flush_i;
  logic [4:0]  rs1_addr_o;
  logic [4:0]  rs2_addr_o;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [31:0] out_imm;
  logic [4:0]  out_rd;
  logic        out_rd_we;
  logic        out_rs1_en;
  logic        out_rs2_en;
  logic        out_illegal;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  decode_queue #(.XLEN(32), .DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .flush_i(flush_i),
    .rs1_addr_o(rs1_addr_o), .rs2_addr_o(rs2_addr_o),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_pc(out_pc), .out_imm(out_imm), .out_rd(out_rd), .out_rd_we(out_rd_we),
    .out_rs1_en(out_rs1_en), .out_rs2_en(out_rs2_en), .out_illegal(out_illegal)
  );

  // Decode vector table: instr, rs1 addr, rs2 addr, imm, rd, rd_we, rs1_en, rs2_en, illegal
  localparam int NV = 11;
  logic [31:0] v_instr [NV];
  logic [4:0]  v_rs1a  [NV];
  logic [4:0]  v_rs2a  [NV];
  logic [31:0] v_imm   [NV];
  logic [4:0]  v_rd    [NV];
  logic        v_rdwe  [NV];
  logic        v_r1en  [NV];
  logic        v_r2en  [NV];
  logic        v_ill   [NV];

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_instr = 32'd0; in_pc = 32'd0;
    flush_i = 1'b0; out_ready = 1'b0;
    #2;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (out_instr !== 32'd0) begin errors++; $display("FAIL reset_out_instr got %h want 0", out_instr); end
    checks++; if (out_imm !== 32'd0) begin errors++; $display("FAIL reset_out_imm got %h want 0", out_imm); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid_post got %b want 0", out_valid); end
  endtask

  task automatic test_decode();
    v_instr = '{32'hFFB10093, 32'h00532423, 32'hFE000EE3, 32'h0000007F, 32'h123452B7,
                32'h008000EF, 32'h002081B3, 32'h00000013, 32'h002080FF, 32'h800012F3, 32'h00C30067};
    v_rs1a  = '{5'd2, 5'd6, 5'd0, 5'd0, 5'd0, 5'd0, 5'd1, 5'd0, 5'd0, 5'd0, 5'd6};
    v_rs2a  = '{5'd0, 5'd5, 5'd0, 5'd0, 5'd0, 5'd0, 5'd2, 5'd0, 5'd0, 5'd0, 5'd0};
    v_imm   = '{32'hFFFFFFFB, 32'h00000008, 32'hFFFFFFFC, 32'h0, 32'h12345000,
                32'h00000008, 32'h0, 32'h0, 32'h0, 32'hFFFFF800, 32'h0000000C};
    v_rd    = '{5'd1, 5'd0, 5'd0, 5'd0, 5'd5, 5'd1, 5'd3, 5'd0, 5'd0, 5'd0, 5'd0};
    v_rdwe  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    v_r1en  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    v_r2en  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    v_ill   = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < NV; i++) begin
      in_valid = 1'b1; in_instr = v_instr[i]; in_pc = 32'h100 + 32'(i * 4); out_ready = 1'b0;
      #1;
      checks++; if (rs1_addr_o !== v_rs1a[i]) begin errors++; $display("FAIL dec%0d_rs1_addr got %0d want %0d", i, rs1_addr_o, v_rs1a[i]); end
      checks++; if (rs2_addr_o !== v_rs2a[i]) begin errors++; $display("FAIL dec%0d_rs2_addr got %0d want %0d", i, rs2_addr_o, v_rs2a[i]); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL dec%0d_early_valid got %b want 0", i, out_valid); end
      @(posedge clk); #1; in_valid = 1'b0; #1;
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL dec%0d_valid got %b want 1", i, out_valid); end
      checks++; if (out_instr !== v_instr[i]) begin errors++; $display("FAIL dec%0d_instr got %h want %h", i, out_instr, v_instr[i]); end
      checks++; if (out_pc !== 32'h100 + 32'(i * 4)) begin errors++; $display("FAIL dec%0d_pc got %h want %h", i, out_pc, 32'h100 + 32'(i * 4)); end
      checks++; if (out_imm !== v_imm[i]) begin errors++; $display("FAIL dec%0d_imm got %h want %h", i, out_imm, v_imm[i]); end
      checks++; if (out_rd !== v_rd[i]) begin errors++; $display("FAIL dec%0d_rd got %0d want %0d", i, out_rd, v_rd[i]); end
      checks++; if (out_rd_we !== v_rdwe[i]) begin errors++; $display("FAIL dec%0d_rd_we got %b want %b", i, out_rd_we, v_rdwe[i]); end
      checks++; if (out_rs1_en !== v_r1en[i]) begin errors++; $display("FAIL dec%0d_rs1_en got %b want %b", i, out_rs1_en, v_r1en[i]); end
      checks++; if (out_rs2_en !== v_r2en[i]) begin errors++; $display("FAIL dec%0d_rs2_en got %b want %b", i, out_rs2_en, v_r2en[i]); end
      checks++; if (out_illegal !== v_ill[i]) begin errors++; $display("FAIL dec%0d_illegal got %b want %b", i, out_illegal, v_ill[i]); end
      out_ready = 1'b1;
      @(posedge clk); #1; out_ready = 1'b0; #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL dec%0d_pop_valid got %b want 0", i, out_valid); end
      checks++; if (out_instr !== 32'd0 || out_imm !== 32'd0 || out_pc !== 32'd0) begin
        errors++; $display("FAIL dec%0d_empty_zero got instr %h imm %h pc %h want 0", i, out_instr, out_imm, out_pc);
      end
    end
  endtask

  task automatic test_stability();
    in_valid = 1'b1; in_instr = 32'h002081B3; in_pc = 32'h200; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0; in_instr = 32'hFFB10093; #1;
    checks++; if (rs1_addr_o !== 5'd2) begin errors++; $display("FAIL stab_rs1_noval got %0d want 2", rs1_addr_o); end
    for (int c = 0; c < 3; c++) begin
      checks++; if (out_valid !== 1'b1 || out_instr !== 32'h002081B3 || out_rd !== 5'd3 || out_pc !== 32'h200) begin
        errors++; $display("FAIL stab_hold%0d got v %b instr %h rd %0d pc %h want 1 002081b3 3 200", c, out_valid, out_instr, out_rd, out_pc);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0; #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stab_pop got %b want 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'h00100093; in_pc = 32'h300; #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_rdy0 got %b want 1", in_ready); end
    @(posedge clk); #1;
    in_instr = 32'h00200113; in_pc = 32'h304; #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_rdy1 got %b want 1", in_ready); end
    @(posedge clk); #1;
    in_instr = 32'h00300193; in_pc = 32'h308; #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_full got %b want 0", in_ready); end
    @(posedge clk); #1;
    checks++; if (out_instr !== 32'h00100093) begin errors++; $display("FAIL b2b_head0 got %h want 00100093", out_instr); end
    out_ready = 1'b1; #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_no_passthru got %b want 0", in_ready); end
    @(posedge clk); #1;
    checks++; if (out_instr !== 32'h00200113) begin errors++; $display("FAIL b2b_head1 got %h want 00200113", out_instr); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_rdy_after_pop got %b want 1", in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0; #1;
    checks++; if (out_valid !== 1'b1 || out_instr !== 32'h00300193 || out_pc !== 32'h308) begin
      errors++; $display("FAIL b2b_head2 got v %b instr %h pc %h want 1 00300193 308", out_valid, out_instr, out_pc);
    end
    @(posedge clk); #1; out_ready = 1'b0; #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drained got %b want 0", out_valid); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'h00100093; in_pc = 32'h400;
    @(posedge clk); #1; in_instr = 32'h00200113; in_pc = 32'h404;
    @(posedge clk); #1;
    in_instr = 32'h00300193; in_pc = 32'h408; flush_i = 1'b1; out_ready = 1'b1; #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready got %b want 0", in_ready); end
    @(posedge clk); #1;
    flush_i = 1'b0; in_valid = 1'b0; out_ready = 1'b0; #1;
    checks++; if (out_valid !== 1'b0 || out_instr !== 32'd0) begin errors++; $display("FAIL flush_empty got v %b instr %h want 0 0", out_valid, out_instr); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_count got in_ready %b want 1", in_ready); end
    in_valid = 1'b1; in_instr = 32'h123452B7; in_pc = 32'h500;
    @(posedge clk); #1; in_valid = 1'b0; #1;
    checks++; if (out_instr !== 32'h123452B7 || out_pc !== 32'h500) begin
      errors++; $display("FAIL flush_refill got instr %h pc %h want 123452b7 500", out_instr, out_pc);
    end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_refill_rdy got %b want 1", in_ready); end
    out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    in_valid = 1'b1; in_instr = 32'hFFB10093; in_pc = 32'h600; out_ready = 1'b0;
    @(posedge clk); #1;
    in_instr = 32'h00532423; in_pc = 32'h604; #1;
    rst_n = 1'b0; #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid got %b want 0", out_valid); end
    checks++; if (out_instr !== 32'd0 || out_pc !== 32'd0 || out_imm !== 32'd0 || out_rd !== 5'd0 || out_rd_we !== 1'b0) begin
      errors++; $display("FAIL rstmid_zero got instr %h pc %h imm %h rd %0d we %b want all 0", out_instr, out_pc, out_imm, out_rd, out_rd_we);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; #2; rst_n = 1'b1; #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_in_ready got %b want 1", in_ready); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_stays_empty got %b want 0", out_valid); end
  endtask

  initial begin
    test_reset();
    test_decode();
    test_stability();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1);
  end

endmodule
